// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package adder_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int BYTE_W = 8;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Requester-index width for the default two-requester configuration.
    localparam int ID_W = id_width(2);

endpackage

// File: rtl/adder.sv
// Team 8-bit prefix adder (Kogge-Stone); carry-in folded in as bit position 0.
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] g0, p0, g1, p1, g2, p2, g3, p3, g4;

    assign g0 = {a & b, cin};
    assign p0 = {a ^ b, 1'b0};
    assign g1 = g0 | (p0 & (g0 << 1));
    assign p1 = p0 & (p0 << 1);
    assign g2 = g1 | (p1 & (g1 << 2));
    assign p2 = p1 & (p1 << 2);
    assign g3 = g2 | (p2 & (g2 << 4));
    assign p3 = p2 & (p2 << 4);
    assign g4 = g3 | (p3 & (g3 << 8));

    // g4[i] is the carry into bit i; g4[8] is the carry out of bit 7.
    assign sum  = p0[8:1] ^ g4[7:0];
    assign cout = g4[8];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter
    import adder_seq_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_seq.sv
// Multi-precision add/subtract sequencer sharing one 8-bit adder among NREQ
// requesters; operands are processed one byte per cycle, LSB first.
module adder_share_seq
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int NREQ   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*8*NBYTES-1:0]    req_a,
    input  logic [NREQ*8*NBYTES-1:0]    req_b,
    input  logic [NREQ-1:0]             req_cin,
    input  logic [NREQ-1:0]             req_sub,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [8*NBYTES-1:0]         rsp_sum,
    output logic                        rsp_cout,
    output logic [id_width(NREQ)-1:0]   rsp_id,
    output logic                        busy
);

    localparam int W   = BYTE_W * NBYTES;
    localparam int IDW = id_width(NREQ);
    localparam int KW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d;
    logic           carry_q, carry_d;
    logic [KW-1:0]  k_q, k_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic [BYTE_W-1:0] add_a, add_b, add_s;
    logic              add_co;
    int                g;

    rr_arbiter #(.N(NREQ), .PW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        ((state_q == IDLE) && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign add_a = a_q[int'(k_q)*BYTE_W +: BYTE_W];
    assign add_b = b_q[int'(k_q)*BYTE_W +: BYTE_W];

    adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        carry_d = carry_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        g       = int'(grant_idx);
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_d = req_a[g*W +: W];
                    // Subtract is A + ~B + 1: invert B once here, force carry-in.
                    b_d     = req_sub[g] ? ~req_b[g*W +: W] : req_b[g*W +: W];
                    carry_d = req_sub[g] ? 1'b1 : req_cin[g];
                    id_d    = grant_idx;
                    ptr_d   = IDW'((g + 1) % NREQ);
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*BYTE_W +: BYTE_W] = add_s;
                carry_d = add_co;
                if (int'(k_q) == NBYTES - 1) state_d = DONE;
                else                         k_d     = k_q + KW'(1);
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // In DONE the carry register holds the final carry out.
    assign req_ready = grant;
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_share_seq.sv
// Self-checking bench for adder_share_seq (NBYTES=4, NREQ=2).
module tb_adder_share_seq;

    localparam int NB = 4;
    localparam int NR = 2;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0, req_ready, req_cin = '0, req_sub = '0;
    logic [NR*W-1:0] req_a = '0, req_b = '0;
    logic            rsp_valid, rsp_ready = 1'b1, rsp_cout, busy;
    logic [W-1:0]    rsp_sum;
    logic [0:0]      rsp_id;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          idx;
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] es;
        logic        ec;
    } vec_t;

    vec_t tbl[7];

    adder_share_seq #(.NBYTES(NB), .NREQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic; for subtract, cout means "no borrow".
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + 33'(cin);
    endfunction

    task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_cin[idx]      = cin;
        req_sub[idx]      = sub;
    endtask

    // Returns at the negedge just after the accept edge.
    task automatic wait_accept(input int idx, input string nm);
        int n;
        n = 0;
        #1;
        while (!req_ready[idx] && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, "_accept"}, 64'(req_ready[idx]), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string nm, input logic [31:0] es, input logic ec, input int eid);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, "_sum"},   64'(rsp_sum),   64'(es));
        chk({nm, "_cout"},  64'(rsp_cout),  64'(ec));
        chk({nm, "_id"},    64'(rsp_id),    64'(eid));
        if (rsp_ready) @(negedge clk);
    endtask

    task automatic do_op(input string nm, input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es, input logic ec);
        int n;
        drive(idx, a, b, cin, sub);
        req_valid[idx] = 1'b1;
        wait_accept(idx, nm);
        req_valid[idx] = 1'b0;
        n = 1;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(NB + 1));
        wait_rsp(nm, es, ec, idx);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] s_hold;
        logic        c_hold;
        logic [0:0]  i_hold;
        bit          stable, rdy0, two_hot, quiet;
        int          gq[$], gt[$], iq[$];
        int          cyc, n;

        tbl[0] = '{0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0};
        tbl[1] = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
        tbl[2] = '{0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0};
        tbl[3] = '{0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0};
        tbl[4] = '{0, 32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1};
        tbl[5] = '{1, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000001, 1'b1};
        tbl[6] = '{1, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};

        // Reset state, with requests present to show req_ready stays low.
        rst = 1'b1;
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_sum",       64'(rsp_sum),   64'd0);
        chk("rst_cout",      64'(rsp_cout),  64'd0);
        chk("rst_id",        64'(rsp_id),    64'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i])
            do_op($sformatf("vec%0d", i), tbl[i].idx, tbl[i].a, tbl[i].b,
                  tbl[i].cin, tbl[i].sub, tbl[i].es, tbl[i].ec);

        for (int i = 0; i < 16; i++) begin
            int          idx;
            logic [31:0] a, b;
            logic        cin, sub;
            idx = int'($urandom_range(0, 1));
            a   = $urandom;
            b   = (i % 4 == 0) ? ~a : $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
            e   = model(a, b, cin, sub);
            do_op($sformatf("rnd%0d", i), idx, a, b, cin, sub, e[31:0], e[32]);
        end

        // Contention: both requesters valid continuously from reset release.
        rst = 1'b1;
        drive(0, 32'd1, 32'd2, 1'b0, 1'b0);
        drive(1, 32'd10, 32'd20, 1'b0, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        two_hot = 1'b0;
        while (cyc < 100 && (gq.size() < 4 || iq.size() < 4)) begin
            #1;
            if (req_ready == 2'b11) two_hot = 1'b1;
            if (req_ready != 2'b00) begin
                gq.push_back(req_ready[1] ? 1 : 0);
                gt.push_back(cyc);
            end
            if (rsp_valid) iq.push_back(int'(rsp_id));
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        chk("cont_two_hot", 64'(two_hot), 64'd0);
        chk("cont_ngrant",  64'(gq.size() >= 4), 64'd1);
        chk("cont_nrsp",    64'(iq.size() >= 4), 64'd1);
        if (gq.size() >= 4 && iq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cont_grant%0d", i), 64'(gq[i]), 64'(i % 2));
                chk($sformatf("cont_rspid%0d", i), 64'(iq[i]), 64'(i % 2));
                if (i > 0) chk($sformatf("cont_gap%0d", i), 64'(gt[i] - gt[i-1]), 64'(NB + 2));
            end
        end
        wait_idle("cont");

        // Backpressure: hold DONE for 10 cycles with another requester waiting.
        rsp_ready = 1'b0;
        drive(0, 32'h12345678, 32'h11111111, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        wait_accept(0, "bp0");
        req_valid[0] = 1'b0;
        drive(1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
        req_valid[1] = 1'b1;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        #1;
        s_hold = rsp_sum;
        c_hold = rsp_cout;
        i_hold = rsp_id;
        stable = 1'b1;
        rdy0   = 1'b1;
        repeat (10) begin
            @(negedge clk); #1;
            if (rsp_sum !== s_hold || rsp_cout !== c_hold || rsp_id !== i_hold || rsp_valid !== 1'b1)
                stable = 1'b0;
            if (req_ready !== 2'b00) rdy0 = 1'b0;
        end
        e = model(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        chk("bp_stable",    64'(stable), 64'd1);
        chk("bp_ready_low", 64'(rdy0),   64'd1);
        chk("bp_sum",       64'(s_hold), 64'(e[31:0]));
        chk("bp_cout",      64'(c_hold), 64'(e[32]));
        chk("bp_id",        64'(i_hold), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_next_accept", 64'(req_ready), 64'b10);
        @(negedge clk);
        req_valid[1] = 1'b0;
        e = model(32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
        wait_rsp("bp1", e[31:0], e[32], 1);

        // Reset in RUN at byte 2 aborts; pointer returns to 0.
        drive(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        req_valid[0] = 1'b1;
        wait_accept(0, "rr0");
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rr_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rr_busy",      64'(busy),      64'd0);
        chk("rr_sum",       64'(rsp_sum),   64'd0);
        chk("rr_cout",      64'(rsp_cout),  64'd0);
        chk("rr_id",        64'(rsp_id),    64'd0);
        chk("rr_ready",     64'(req_ready), 64'd0);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) quiet = 1'b0;
        end
        chk("rr_no_rsp", 64'(quiet), 64'd1);
        drive(0, 32'd3, 32'd4, 1'b0, 1'b0);
        drive(1, 32'h00000100, 32'h00000001, 1'b0, 1'b1);
        req_valid = 2'b11;
        #1;
        chk("rr_prio0", 64'(req_ready), 64'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp("rr_op0", 32'd7, 1'b0, 0);
        #1;
        chk("rr_then1", 64'(req_ready), 64'b10);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp("rr_op1", 32'h000000FF, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_seq.md
Name: adder_share_seq

Overview:
- Multi-precision add/subtract sequencer that time-shares one instance of the team's 8-bit prefix adder (`adder`: 8-bit a/b, cin, sum, cout) between NREQ requesters.
- Each operation is processed one byte per cycle, LSB first. The adder's cout is registered and fed back as the next byte's cin.
- Sits between client blocks and the adder network. It owns arbitration, the operand/result buffers and the carry chaining.

Parameters:
- NBYTES, 4: operand width in bytes. Operand width W = 8*NBYTES. Legal range 1..16.
- NREQ, 2: number of requesters. Legal range 2..8.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*W  operand A; requester i occupies slice [i*W +: W].
- req_b  in  NREQ*W  operand B; same slicing as req_a.
- req_cin  in  NREQ  carry-in for add; ignored when req_sub is 1.
- req_sub  in  NREQ  1 = compute A - B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  W  result.
- rsp_cout  out  1  final carry out; for subtract, 1 = no borrow.
- rsp_id  out  ID_W  index of the requester that owns the result; ID_W = max(1, clog2(NREQ)).
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset (synchronous, active-high): state = IDLE.
  - rsp_valid = 0, req_ready = 0, busy = 0.
  - rsp_sum = 0, rsp_cout = 0, rsp_id = 0.
  - Round-robin pointer = 0; carry register = 0; byte index = 0.
- Reset asserted mid-operation aborts the operation. No response is produced and the pointer returns to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready is driven combinationally, one-hot, only in IDLE.
  - The granted requester g is the first asserted req_valid at or after the round-robin pointer, scanning upward and wrapping.
  - On the accept cycle:
    - Capture A and B.
    - If req_sub[g] = 1, capture ~B and set carry = 1; otherwise carry = req_cin[g].
    - Capture id = g; set pointer = (g+1) mod NREQ; go to RUN with byte index k = 0.
  - No req_valid asserted: remain in IDLE.
- RUN:
  - Adder inputs: a = A byte k, b = B' byte k, cin = carry register.
  - At the clock edge: sum byte k is stored into the result buffer, carry register <= cout, k <= k+1.
  - After byte NBYTES-1 is stored, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_cout and rsp_id are registered outputs.
  - Outputs are held stable while rsp_ready = 0.
  - On rsp_valid && rsp_ready, go to IDLE with rsp_valid = 0.
- Latency:
  - Accept at cycle T gives rsp_valid first high at T+NBYTES+1.
  - Peak throughput is one operation per NBYTES+2 cycles; there is no overlap of accept and respond.
- Arithmetic:
  - Result = (A + B + cin) mod 2^W, cout = carry out of bit W-1.
  - Subtract = A + ~B + 1.
- Boundary conditions:
  - req_valid may drop before grant; no state is kept for ungranted requests.
  - Requesters must hold operands only until their accept cycle.
  - Simultaneous requests are resolved purely by the pointer; with all requesters continuously valid, grants rotate 0,1,...,NREQ-1.
  - The byte index does not wrap; k = NBYTES-1 is terminal.
  - NBYTES = 1: RUN lasts exactly one cycle.

Decomposition:
- Shared package adder_seq_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam ID_W;
  - byte-width constant BYTE_W = 8.
- Sub-module rr_arbiter:
  - parameter N; inputs req[N], pointer, en; output grant[N] (one-hot) and grant_idx.
  - Purely combinational; the pointer register lives in the parent.
- Datapath: one instance of the existing `adder`; no modification to it.

Test Plan (NBYTES=4, NREQ=2):
- Single add: req0 a=0x000000FF, b=0x00000001, cin=0 → sum 0x00000100, cout 0, id 0; rsp_valid exactly 5 cycles after accept.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum 0x00000000, cout 1.
- Cin only: a=0, b=0, cin=1 → sum 0x00000001, cout 0.
- Subtract:
  - a=0x00000005, b=0x00000007, sub=1, cin=1 → sum 0xFFFFFFFE, cout 0.
  - a=7, b=5 → sum 0x00000002, cout 1.
- Contention: req0 and req1 both valid from reset release with rsp_ready=1 → grants 0,1,0,1; req_ready never two-hot; rsp_id alternates.
- Backpressure: rsp_ready=0 for 10 cycles in DONE → rsp_sum/rsp_cout/rsp_id stable, req_ready=0 throughout; release → next accept one cycle after the response handshake.
- Reset mid-RUN (k=2) → no rsp_valid; all outputs zero next cycle; a subsequent op from req1 completes correctly, and req0 has priority if both request.
